// File: rtl/cp0_regfile.sv
// -----------------------------------------------------------------------------
// cp0_regfile -- coprocessor-0 register file with exception/interrupt control.
//
// Holds SR (12), Cause (13), EPC (14) and PRId (15). It decides combinationally
// whether the M-stage instruction must be replaced by an exception entry
// (IntReq). On the clock edge where IntReq is high it captures the EPC and
// Cause fields and enters the handler state (EXL=1). eret (EXLClr) returns it
// to normal operation.
//
// Ports:
//   clk        in   1  sole clock, rising edge
//   reset      in   1  asynchronous active-high reset
//   A1         in   5  mfc0 read select
//   A2         in   5  mtc0 write select
//   DIn        in  32  mtc0 write data
//   WE         in   1  mtc0 write enable
//   VPC        in  32  PC of the M-stage instruction
//   BDIn       in   1  M-stage instruction is in a branch delay slot
//   ExcCodeIn  in   5  synchronous exception code (0 = none)
//   HWInt      in   6  level-sensitive hardware interrupt lines
//   EXLClr     in   1  eret in M stage
//   IntReq     out  1  take-exception request
//   EPCOut     out 32  current EPC
//   DOut       out 32  read data for A1
// -----------------------------------------------------------------------------
module cp0_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        WE,
    input  logic [31:0] VPC,
    input  logic        BDIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic        IntReq,
    output logic [31:0] EPCOut,
    output logic [31:0] DOut
);

    localparam logic [31:0] PRID_VALUE = 32'h1800_0001;

    // EXL is not stored separately: it is the FSM state itself.
    typedef enum logic {
        NORMAL  = 1'b0,
        HANDLER = 1'b1
    } state_t;

    state_t      state, state_next;
    logic [5:0]  im, im_next;
    logic        ie, ie_next;
    logic        bd, bd_next;
    logic [5:0]  ip;
    logic [4:0]  exc_code, exc_code_next;
    logic [29:0] epc, epc_next;          // EPC[31:2]; low bits are always zero

    logic        exl;
    logic        int_pend;
    logic        exc_pend;
    logic        sr_write;
    logic        epc_write;
    logic [31:0] vpc_adj;
    logic        unused_bits;

    assign exl      = (state == HANDLER);
    assign int_pend = (|(HWInt & im)) & ie & ~exl;
    assign exc_pend = (ExcCodeIn != 5'd0) & ~exl;
    // ExcCodeIn can be nonzero while reset is held; reset must still force 0.
    assign IntReq   = (int_pend | exc_pend) & ~reset;

    // A taken exception squashes the same-cycle mtc0 entirely.
    assign sr_write  = WE & ~IntReq & (A2 == 5'd12);
    assign epc_write = WE & ~IntReq & (A2 == 5'd14);

    // Delay-slot instructions restart at the branch (VPC-4), wrapping mod 2^32.
    assign vpc_adj     = BDIn ? (VPC - 32'd4) : VPC;
    assign unused_bits = ^vpc_adj[1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= NORMAL;
            im       <= 6'd0;
            ie       <= 1'b0;
            bd       <= 1'b0;
            ip       <= 6'd0;
            exc_code <= 5'd0;
            epc      <= 30'd0;
        end else begin
            state    <= state_next;
            im       <= im_next;
            ie       <= ie_next;
            bd       <= bd_next;
            ip       <= HWInt;           // IP tracks the lines every cycle
            exc_code <= exc_code_next;
            epc      <= epc_next;
        end
    end

    always_comb begin
        state_next    = state;
        im_next       = im;
        ie_next       = ie;
        bd_next       = bd;
        exc_code_next = exc_code;
        epc_next      = epc;

        case (state)
            NORMAL: begin
                if (IntReq) begin
                    state_next = HANDLER;
                end else if (sr_write && DIn[1] && !EXLClr) begin
                    state_next = HANDLER;
                end
            end
            HANDLER: begin
                // eret wins over an mtc0 that tries to keep EXL set.
                if (EXLClr) begin
                    state_next = NORMAL;
                end else if (sr_write && !DIn[1]) begin
                    state_next = NORMAL;
                end
            end
            default: state_next = NORMAL;
        endcase

        // IntReq can only be high in NORMAL, so nested exceptions never
        // overwrite the captured BD/ExcCode/EPC.
        if (IntReq) begin
            bd_next       = BDIn;
            exc_code_next = int_pend ? 5'd0 : ExcCodeIn;
            epc_next      = vpc_adj[31:2];
        end

        if (sr_write) begin
            im_next = DIn[15:10];
            ie_next = DIn[0];
        end

        if (epc_write) begin
            epc_next = DIn[31:2];
        end
    end

    assign EPCOut = {epc, 2'b00};

    always_comb begin
        case (A1)
            5'd12:   DOut = {16'h0000, im, 8'h00, exl, ie};
            5'd13:   DOut = {bd, 15'h0000, ip, 3'b000, exc_code, 2'b00};
            5'd14:   DOut = {epc, 2'b00};
            5'd15:   DOut = PRID_VALUE;
            default: DOut = 32'h0000_0000;
        endcase
    end

endmodule

// File: tb/tb_cp0_regfile.sv
// -----------------------------------------------------------------------------
// tb_cp0_regfile -- scoreboard bench for cp0_regfile.
// Stimulus is applied 1 time unit after each rising edge; the expected outputs
// for that cycle are produced by a register-level reference model and queued.
// A monitor on the falling edge pops one entry per cycle and compares it.
// -----------------------------------------------------------------------------
module tb_cp0_regfile;

    logic        clk;
    logic        reset;
    logic [4:0]  a1, a2;
    logic [31:0] din;
    logic        we;
    logic [31:0] vpc;
    logic        bdin;
    logic [4:0]  exc_in;
    logic [5:0]  hwint;
    logic        exlclr;
    logic        int_req;
    logic [31:0] epc_out;
    logic [31:0] dout;

    cp0_regfile dut (
        .clk       (clk),
        .reset     (reset),
        .A1        (a1),
        .A2        (a2),
        .DIn       (din),
        .WE        (we),
        .VPC       (vpc),
        .BDIn      (bdin),
        .ExcCodeIn (exc_in),
        .HWInt     (hwint),
        .EXLClr    (exlclr),
        .IntReq    (int_req),
        .EPCOut    (epc_out),
        .DOut      (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          id;
        logic        ireq;
        logic [31:0] epc;
        logic [31:0] dout;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   n_tx   = 0;

    // Reference model: architectural fields kept as plain values.
    logic [5:0]  m_im;
    logic        m_ie;
    logic        m_exl;
    logic        m_bd;
    logic [5:0]  m_ip;
    logic [4:0]  m_exc;
    logic [31:0] m_epc;

    function automatic logic [31:0] model_read(input logic [4:0] addr);
        logic [31:0] v;
        v = 32'd0;
        if (addr == 5'd12)
            v = (32'(m_im) << 10) | (32'(m_exl) << 1) | 32'(m_ie);
        else if (addr == 5'd13)
            v = (32'(m_bd) << 31) | (32'(m_ip) << 10) | (32'(m_exc) << 2);
        else if (addr == 5'd14)
            v = m_epc;
        else if (addr == 5'd15)
            v = 32'h1800_0001;
        return v;
    endfunction

    task automatic model_clear();
        m_im = 0; m_ie = 0; m_exl = 0; m_bd = 0; m_ip = 0; m_exc = 0; m_epc = 0;
    endtask

    task automatic step(input string name, input logic rst,
                        input logic [4:0] ra, input logic [4:0] wa,
                        input logic [31:0] wd, input logic wen,
                        input logic [31:0] pc, input logic bds,
                        input logic [4:0] exc, input logic [5:0] hw,
                        input logic eret);
        exp_t e;
        logic ipend, epend, take;
        @(posedge clk);
        #1;
        reset = rst; a1 = ra; a2 = wa; din = wd; we = wen; vpc = pc;
        bdin = bds; exc_in = exc; hwint = hw; exlclr = eret;

        if (rst) model_clear();
        ipend = ((hw & m_im) != 6'd0) && m_ie && !m_exl;
        epend = (exc != 5'd0) && !m_exl;
        take  = !rst && (ipend || epend);

        e.name = name;
        e.id   = n_tx;
        e.ireq = take;
        e.epc  = m_epc;
        e.dout = model_read(ra);
        sb.push_back(e);
        n_tx++;

        // State after the coming edge (unchanged while reset is held).
        if (!rst) begin
            m_ip = hw;
            if (take) begin
                m_exl = 1'b1;
                m_bd  = bds;
                m_exc = ipend ? 5'd0 : exc;
                m_epc = (bds ? pc - 32'd4 : pc) & 32'hFFFF_FFFC;
            end else begin
                if (eret) m_exl = 1'b0;
                if (wen && wa == 5'd12) begin
                    m_im = wd[15:10];
                    m_ie = wd[0];
                    if (!eret) m_exl = wd[1];
                end
                if (wen && wa == 5'd14) m_epc = wd & 32'hFFFF_FFFC;
            end
        end
    endtask

    // Monitor: one comparison set per queued transaction.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic bad;
            e = sb.pop_front();
            bad = 1'b0;
            n_cmp++;
            if (int_req !== e.ireq) begin
                n_fail++; bad = 1'b1;
                $display("FAIL tx %0d %s IntReq: got %b want %b", e.id, e.name, int_req, e.ireq);
            end
            n_cmp++;
            if (epc_out !== e.epc) begin
                n_fail++; bad = 1'b1;
                $display("FAIL tx %0d %s EPCOut: got %h want %h", e.id, e.name, epc_out, e.epc);
            end
            n_cmp++;
            if (dout !== e.dout) begin
                n_fail++; bad = 1'b1;
                $display("FAIL tx %0d %s DOut(A1=%0d): got %h want %h", e.id, e.name, a1, dout, e.dout);
            end
            if (!bad)
                $display("tx %0d %s: A1=%0d IntReq=%b EPCOut=%h DOut=%h ok",
                         e.id, e.name, a1, int_req, epc_out, dout);
        end
    end

    initial begin
        logic [31:0] r;
        logic [4:0]  ra, wa;
        reset = 1'b1; a1 = 0; a2 = 0; din = 0; we = 0; vpc = 0;
        bdin = 0; exc_in = 0; hwint = 0; exlclr = 0;
        model_clear();

        //   name          rst A1     A2     DIn            WE  VPC            BD  Exc    HW        ERET
        step("rst_hold",   1, 5'd12, 5'd0,  32'h0,         0, 32'h0,         0, 5'd7,  6'h3F,    0);
        step("rst_rel",    0, 5'd13, 5'd0,  32'h0,         0, 32'h0,         0, 5'd0,  6'h00,    0);
        // Load SR/EPC, then reset mid-run.
        step("wr_sr",      0, 5'd12, 5'd12, 32'h0000_FC01, 1, 32'h3000,      0, 5'd0,  6'h00,    0);
        step("wr_epc",     0, 5'd12, 5'd14, 32'h0000_3000, 1, 32'h3004,      0, 5'd0,  6'h00,    0);
        step("chk_pre",    0, 5'd14, 5'd0,  32'h0,         0, 32'h3008,      0, 5'd0,  6'h00,    0);
        step("rst_sr",     1, 5'd12, 5'd0,  32'h0,         0, 32'h0,         0, 5'd3,  6'h3F,    0);
        step("rst_epc",    1, 5'd14, 5'd0,  32'h0,         0, 32'h0,         0, 5'd0,  6'h00,    0);
        step("rst_off",    0, 5'd12, 5'd0,  32'h0,         0, 32'h0,         0, 5'd0,  6'h00,    0);
        // Interrupt entry.
        step("int_setup",  0, 5'd12, 5'd12, 32'h0000_0401, 1, 32'h300C,      0, 5'd0,  6'h00,    0);
        step("int_take",   0, 5'd12, 5'd0,  32'h0,         0, 32'h3010,      0, 5'd0,  6'h01,    0);
        step("int_cause",  0, 5'd13, 5'd0,  32'h0,         0, 32'h3014,      0, 5'd0,  6'h01,    0);
        step("int_sr",     0, 5'd12, 5'd0,  32'h0,         0, 32'h3018,      0, 5'd0,  6'h01,    0);
        // Masked in handler, then eret re-evaluates.
        step("nest_mask",  0, 5'd14, 5'd0,  32'h0,         0, 32'h3040,      0, 5'd10, 6'h01,    0);
        step("eret",       0, 5'd14, 5'd0,  32'h0,         0, 32'h3044,      0, 5'd0,  6'h01,    1);
        step("post_eret",  0, 5'd12, 5'd0,  32'h0,         0, 32'h3048,      0, 5'd0,  6'h01,    0);
        // Leave handler via mtc0 SR=0 (IE=0), then a delay-slot exception.
        step("sr_clear",   0, 5'd12, 5'd12, 32'h0,         1, 32'h304C,      0, 5'd0,  6'h00,    0);
        step("exc_take",   0, 5'd13, 5'd0,  32'h0,         0, 32'h3024,      1, 5'd4,  6'h00,    0);
        step("exc_cause",  0, 5'd13, 5'd0,  32'h0,         0, 32'h3028,      0, 5'd0,  6'h00,    0);
        // mtc0 EPC suppressed by a same-cycle exception, then accepted.
        step("leave",      0, 5'd12, 5'd12, 32'h0,         1, 32'h302C,      0, 5'd0,  6'h00,    0);
        step("wepc_sup",   0, 5'd14, 5'd14, 32'h0000_4003, 1, 32'h5000,      0, 5'd3,  6'h00,    0);
        step("wepc_chk",   0, 5'd14, 5'd0,  32'h0,         0, 32'h5004,      0, 5'd0,  6'h00,    1);
        step("wepc_ok",    0, 5'd14, 5'd14, 32'h0000_4003, 1, 32'h5008,      0, 5'd0,  6'h00,    0);
        step("wepc_rd",    0, 5'd14, 5'd0,  32'h0,         0, 32'h500C,      0, 5'd0,  6'h00,    0);
        // Cause.IP, PRId, unmapped address, EPC wrap on VPC=0 in delay slot.
        step("ip_pulse",   0, 5'd13, 5'd0,  32'h0,         0, 32'h5010,      0, 5'd0,  6'h20,    0);
        step("ip_read",    0, 5'd13, 5'd0,  32'h0,         0, 32'h5014,      0, 5'd0,  6'h00,    0);
        step("prid",       0, 5'd15, 5'd15, 32'hFFFF_FFFF, 1, 32'h5018,      0, 5'd0,  6'h00,    0);
        step("unmapped",   0, 5'd3,  5'd13, 32'hFFFF_FFFF, 1, 32'h501C,      0, 5'd0,  6'h00,    0);
        step("sr_eret_we", 0, 5'd12, 5'd12, 32'h0000_FC03, 1, 32'h5020,      0, 5'd0,  6'h00,    1);
        step("sr_after",   0, 5'd12, 5'd0,  32'h0,         0, 32'h0,         1, 5'd9,  6'h00,    0);
        step("wrap_rd",    0, 5'd14, 5'd0,  32'h0,         0, 32'h5024,      0, 5'd0,  6'h00,    1);

        // Randomized traffic with occasional asynchronous resets.
        for (int i = 0; i < 250; i++) begin
            r  = $urandom;
            ra = (r[2:0] < 3'd5) ? (5'd12 + 5'(r[4:3])) : r[9:5];
            wa = (r[12:10] < 3'd5) ? (5'd12 + 5'(r[14:13])) : r[19:15];
            step("rand",
                 ($urandom_range(0, 99) < 3),
                 ra, wa, $urandom, r[20], $urandom, r[21],
                 (r[23:22] == 2'd0) ? 5'($urandom_range(1, 31)) : 5'd0,
                 (r[25:24] == 2'd0) ? 6'($urandom) : 6'd0,
                 (r[28:26] == 3'd0));
        end

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
